stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
- Downstream consumer of the button debouncer's `cnt_en` run/pause level.
- Counts elapsed time in BCD, format SS.cc: seconds 00-59, hundredths 00-99.
- Digits go to the seven-segment display mux.
- A clock-enable prescaler sets the count rate. Pausing holds both the digits and the prescaler phase.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per hundredth-second tick (100 MHz -> 100 Hz); legal range 2 .. 2^24
- PRE_W, 24, prescaler width; must satisfy 2^PRE_W >= TICK_DIV

Ports:
- clk      input   1   system clock; all logic on rising edge
- reset    input   1   synchronous, active-high reset
- cnt_en   input   1   run (1) / pause (0) level from the debouncer; already synchronous to clk
- clr      input   1   synchronous clear; single-cycle pulse or level
- digits   output  16  BCD {sec_tens[15:12], sec_ones[11:8], cs_tens[7:4], cs_ones[3:0]}
- tick     output  1   one-cycle pulse, high in the cycle digits advance
- wrap     output  1   one-cycle pulse, high in the cycle digits roll 59.99 -> 00.00

Behaviour:
- Reset is synchronous and active-high; it has priority over all other inputs.
- Reset values: prescaler = 0, digits = 16'h0000, tick = 0, wrap = 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Priority per edge: reset > clr > count > hold.
- clr (reset low):
  - prescaler <= 0, digits <= 0, tick <= 0, wrap <= 0.
  - clr wins over a coincident tick; no wrap is ever reported on a clear.
- Count, when cnt_en = 1 and clr = 0:
  - If prescaler == TICK_DIV-1: prescaler <= 0, digits advance by one hundredth, tick <= 1.
  - Otherwise: prescaler <= prescaler + 1, tick <= 0.
- Hold, when cnt_en = 0 (and clr = 0):
  - Prescaler and digits hold their values; tick <= 0, wrap <= 0.
  - On resume the count continues from the held prescaler phase. The phase is not restarted.
- Latency: from a state with prescaler = 0, the first digit update is visible after the TICK_DIV-th consecutive enabled edge.
- Digit advance, as a ripple of carries:
  - cs_ones 0-9; at 9 it goes to 0 and carries.
  - cs_tens 0-9; at 9 with carry in it goes to 0 and carries.
  - sec_ones 0-9; at 9 with carry in it goes to 0 and carries.
  - sec_tens 0-5; at 5 with carry in it goes to 0 and raises wrap.
- Each digit changes only when all lower digits are at their maximum.
- wrap <= 1 only on the advance from 16'h5999 to 16'h0000; otherwise wrap <= 0.
- wrap and tick are both high in that cycle.
- Digits never hold a non-BCD value, and sec_tens never exceeds 5.
- Illegal values (possible only through X or unknown state) are not reachable after reset; no recovery logic is required.
- Reset asserted mid-count, or with cnt_en high, gives the reset values on the next edge. Counting resumes only after reset is released, with the full TICK_DIV latency.
- cnt_en toggling every cycle is legal: the prescaler advances only on enabled edges, with no lost or duplicate ticks.

Test Plan (TICK_DIV = 4 unless stated):
1. Reset 2 cycles, then cnt_en = 1 for 4 edges -> digits = 16'h0001 and tick = 1 after the 4th edge. tick = 0 after edges 1-3 and edge 5.
2. Preload by running 99 ticks (396 enabled edges) -> digits = 16'h0099. The next tick gives 16'h0100. Continue to 16'h0999 -> next tick gives 16'h1000.
3. Run to 16'h5999, then one more tick -> digits = 16'h0000, wrap = 1 and tick = 1 for exactly that cycle. The next tick gives 16'h0001 with wrap = 0.
4. Run 2 enabled edges (prescaler = 2), drop cnt_en for 10 cycles, raise it again -> digits are unchanged while paused. The next tick arrives after exactly 2 further enabled edges.
5. Assert clr in the same cycle the prescaler is at 3 with digits = 16'h5999 -> digits = 16'h0000 and wrap = 0, tick = 0. The next tick needs 4 fresh enabled edges.
6. Assert reset for 1 cycle mid-count at digits = 16'h2345 with cnt_en held high -> outputs read zero after that edge, and 16'h0001 appears 4 edges after reset is released. With TICK_DIV = 2, toggle cnt_en every cycle for 40 cycles -> digits = 16'h0010.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: a prescaler-gated BCD counter showing SS.cc (00.00-59.99).
// A pause freezes both the digits and the prescaler phase, so a resumed run continues mid-tick.
module stopwatch_counter #(
    parameter int TICK_DIV = 1_000_000,
    parameter int PRE_W    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_en,
    input  logic        clr,
    output logic [15:0] digits,
    output logic        tick,
    output logic        wrap
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [15:0]      digits_reg, digits_next;
    logic             tick_reg, tick_next;
    logic             wrap_reg, wrap_next;
    logic             terminal;
    logic [15:0]      digits_adv;
    logic [4:0]       carry;

    assign terminal = (pre_reg == PRE_LAST);
    assign carry[0] = 1'b1;

    // Ripple carry through the four BCD digits; the top digit rolls at 5 instead of 9.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DMAX = (gi == 3) ? 4'd5 : 4'd9;
            logic [3:0] dig;
            assign dig          = digits_reg[gi*4 +: 4];
            assign carry[gi+1]  = carry[gi] & (dig == DMAX);
            assign digits_adv[gi*4 +: 4] = carry[gi] ? ((dig == DMAX) ? 4'd0 : dig + 4'd1) : dig;
        end
    endgenerate

    always_comb begin
        pre_next    = pre_reg;
        digits_next = digits_reg;
        tick_next   = 1'b0;
        wrap_next   = 1'b0;
        if (clr) begin
            pre_next    = '0;
            digits_next = 16'h0000;
        end else if (cnt_en) begin
            if (terminal) begin
                pre_next    = '0;
                digits_next = digits_adv;
                tick_next   = 1'b1;
                wrap_next   = carry[4];
            end else begin
                pre_next = pre_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg    <= '0;
            digits_reg <= 16'h0000;
            tick_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            pre_reg    <= pre_next;
            digits_reg <= digits_next;
            tick_reg   <= tick_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign digits = digits_reg;
    assign tick   = tick_reg;
    assign wrap   = wrap_reg;

endmodule
